// File: rtl/r_ser_pkg.sv
// Shared definitions for the r_ser parallel-in/serial-out transmitter.
package r_ser_pkg;

  // Transmitter control states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Width of a counter that must hold the values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/r_shreg.sv
// N-bit loadable shift register with zero fill and a selectable shift direction.
// The serial output is the bit that leaves the register on the next shift.
module r_shreg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic         dir,    // 1: shift right (LSB out), 0: shift left (MSB out)
  input  logic [N-1:0] d,
  output logic         so
);

  logic [N-1:0] r_q;

  // Load has priority over shift; vacated positions fill with zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (shift) begin
      if (dir) r_q <= {1'b0, r_q[N-1:1]};
      else     r_q <= {r_q[N-2:0], 1'b0};
    end
  end

  assign so = dir ? r_q[0] : r_q[N-1];

endmodule

// File: rtl/r_ser.sv
// Parallel-in, serial-out transmitter with an en/rdy load handshake.
// z comes straight from the shift register flop; zv is the state flop and
// done is a flop that anticipates the last-bit cycle, so all three are
// registered. rdy is decoded from state and counter.
module r_ser
  import r_ser_pkg::*;
#(
  parameter int N         = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] x,
  input  logic         en,
  output logic         rdy,
  output logic         z,
  output logic         zv,
  output logic         done
);

  localparam int             CW   = cnt_width(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);
  localparam logic           DIR  = (LSB_FIRST != 0);

  ser_state_t    r_state;
  ser_state_t    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_done;
  logic          w_load;
  logic          w_shift;
  logic          w_last;

  assign w_last  = (r_state == SHIFT) && (r_cnt == LAST);
  assign rdy     = (r_state == IDLE) || w_last;
  assign w_load  = en && rdy;
  // While a word is in flight the register shifts every cycle, except at the
  // last-bit edge when a back-to-back load overwrites it instead.
  assign w_shift = (r_state == SHIFT) && !w_load;

  // Next-state and counter: a load always restarts the count at 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_load) begin
      w_state_nxt = SHIFT;
      w_cnt_nxt   = '0;
    end else if (w_last) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == SHIFT) begin
      w_cnt_nxt   = r_cnt + 1'b1;
    end
  end

  // State, counter and done flop; done is set on the edge entering the last bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= (w_state_nxt == SHIFT) && (w_cnt_nxt == LAST);
    end
  end

  r_shreg #(.N(N)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .shift (w_shift),
    .dir   (DIR),
    .d     (x),
    .so    (z)
  );

  assign zv   = (r_state == SHIFT);
  assign done = r_done;

endmodule

// File: tb/tb_r_ser.sv
// Directed scoreboard bench for r_ser: an LSB-first and an MSB-first instance
// share stimulus; expected {z,zv,done,rdy} per cycle is queued when a word or
// idle cycle is driven and popped one entry per clock.
module tb_r_ser;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [N-1:0] x;
  logic         z_l, zv_l, done_l, rdy_l;
  logic         z_m, zv_m, done_m, rdy_m;

  logic [3:0]   q_l[$];
  logic [3:0]   q_m[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;

  r_ser #(.N(N), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset(reset), .x(x), .en(en),
    .rdy(rdy_l), .z(z_l), .zv(zv_l), .done(done_l)
  );

  r_ser #(.N(N), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .x(x), .en(en),
    .rdy(rdy_m), .z(z_m), .zv(zv_m), .done(done_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed{z,zv,done,rdy}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Outputs of both instances must be in the idle/reset shape right now.
  task automatic chk_now(input string tag);
    chk({tag, "_lsb"}, {z_l, zv_l, done_l, rdy_l}, 4'b0001);
    chk({tag, "_msb"}, {z_m, zv_m, done_m, rdy_m}, 4'b0001);
  endtask

  task automatic push_word(input logic [N-1:0] w);
    for (int k = 0; k < N; k++) begin
      q_l.push_back({w[k],       1'b1, 1'(k == N-1), 1'(k == N-1)});
      q_m.push_back({w[N-1-k],   1'b1, 1'(k == N-1), 1'(k == N-1)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (q_l.size() == 0 || q_m.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_c%0d observed queue sizes=%0d/%0d required>0", cyc, q_l.size(), q_m.size());
    end else begin
      chk($sformatf("lsb_c%0d", cyc), {z_l, zv_l, done_l, rdy_l}, q_l.pop_front());
      chk($sformatf("msb_c%0d", cyc), {z_m, zv_m, done_m, rdy_m}, q_m.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      en = 1'b0;
      q_l.push_back(4'b0001);
      q_m.push_back(4'b0001);
      tick();
    end
  endtask

  // Load w at the next edge, then drive the following N-1 cycles. en/x during
  // those cycles come from hold_en/hold_x, with an optional one-cycle pulse.
  // Returns while the last bit is on z, so the caller decides the ending edge.
  task automatic xfer(input logic [N-1:0] w, input logic hold_en, input logic [N-1:0] hold_x,
                      input int pulse_at, input logic [N-1:0] pulse_x);
    en = 1'b1;
    x  = w;
    push_word(w);
    tick();
    for (int k = 1; k < N; k++) begin
      en = hold_en || (k == pulse_at);
      x  = (k == pulse_at) ? pulse_x : hold_x;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    x     = '0;
    #1;
    chk_now("rst_t0");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // Asynchronous reset while idle, no clock edge involved.
    #2 reset = 1'b1;
    #1 chk_now("rst_idle");
    #1 reset = 1'b0;

    // Single words, returning to idle.
    xfer(8'hA5, 1'b0, 8'h00, 0, 8'h00);
    idle(2);
    xfer(8'h1E, 1'b0, 8'h00, 0, 8'h00);
    idle(1);

    // Back-to-back: FF then 00 with en held high.
    xfer(8'hFF, 1'b1, 8'h00, 0, 8'h00);
    xfer(8'h00, 1'b0, 8'h00, 0, 8'h00);
    idle(2);

    // en pulsed mid-word is ignored; x wiggles after the load.
    xfer(8'hA5, 1'b0, 8'h5A, 3, 8'h0F);
    idle(2);

    // Reset during cycle 4 aborts the word.
    en = 1'b1;
    x  = 8'h96;
    push_word(8'h96);
    tick();
    en = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1 chk_now("rst_abort");
    q_l.delete();
    q_m.delete();
    @(posedge clk);
    #1 chk_now("rst_held");
    reset = 1'b0;
    idle(2);
    xfer(8'h3C, 1'b0, 8'h00, 0, 8'h00);
    idle(2);

    // A chain of random words.
    for (int i = 0; i < 4; i++) begin
      xfer(N'($urandom), 1'b0, N'($urandom), 0, 8'h00);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
